// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, FSM state type and 28-bit rotation helpers.
// Bit numbering follows DES tables: index 1 is the MSB of every vector.
package des_pkg;

   localparam int KEY_W    = 64;
   localparam int CD_W     = 56;
   localparam int HALF_W   = 28;
   localparam int SUBKEY_W = 48;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Left-rotation amount applied when entering each round 1..16
   localparam logic [1:0] SHIFT_SCHED [1:16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   localparam int PC1_TABLE [1:56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   function automatic logic [1:HALF_W] rotl_half(input logic [1:HALF_W] h, input logic [1:0] amt);
      return (amt == 2'd2) ? {h[3:HALF_W], h[1:2]} : {h[2:HALF_W], h[1]};
   endfunction

   function automatic logic [1:HALF_W] rotr_half(input logic [1:HALF_W] h, input logic [1:0] amt);
      return (amt == 2'd2) ? {h[HALF_W-1:HALF_W], h[1:HALF_W-2]} : {h[HALF_W], h[1:HALF_W-1]};
   endfunction

   // C and D rotate independently; the halves never exchange bits
   function automatic logic [1:CD_W] rotl_cd(input logic [1:CD_W] cd, input logic [1:0] amt);
      return {rotl_half(cd[1:HALF_W], amt), rotl_half(cd[HALF_W+1:CD_W], amt)};
   endfunction

   function automatic logic [1:CD_W] rotr_cd(input logic [1:CD_W] cd, input logic [1:0] amt);
      return {rotr_half(cd[1:HALF_W], amt), rotr_half(cd[HALF_W+1:CD_W], amt)};
   endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load request and subkey handshake bundle between the key schedule and its users.
interface des_key_schedule_if;

   logic [1:des_pkg::KEY_W]    key_i;
   logic                       decrypt_i;
   logic                       start_i;
   logic                       subkey_ready_i;
   logic [1:des_pkg::SUBKEY_W] subkey_o;
   logic                       subkey_valid_o;
   logic [3:0]                 round_o;
   logic                       busy_o;
   logic                       done_o;

   modport master (
      output key_i, decrypt_i, start_i, subkey_ready_i,
      input  subkey_o, subkey_valid_o, round_o, busy_o, done_o
   );

   modport slave (
      input  key_i, decrypt_i, start_i, subkey_ready_i,
      output subkey_o, subkey_valid_o, round_o, busy_o, done_o
   );

endinterface

// File: rtl/p_box_56_48.sv
// DES Permuted Choice 2: compresses the 56-bit C/D register into a 48-bit round subkey.
module p_box_56_48 (
   input  logic [1:56] cd,
   output logic [1:48] subkey
);

   localparam int PC2_TABLE [1:48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   for (genvar i = 1; i <= 48; i++) begin : g_bit
      assign subkey[i] = cd[PC2_TABLE[i]];
   end

   // Eight C/D positions never reach the subkey
   logic unused_dropped;
   assign unused_dropped = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/p_box_64_56.sv
// DES Permuted Choice 1: selects the 56 key bits into the C/D register order.
module p_box_64_56
   import des_pkg::*;
(
   input  logic [1:KEY_W] key,
   output logic [1:CD_W]  cd
);

   for (genvar i = 1; i <= CD_W; i++) begin : g_bit
      assign cd[i] = key[PC1_TABLE[i]];
   end

   // Parity bits are dropped by the permutation
   logic unused_parity;
   assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule sequencer: loads PC-1(key) and streams K1..K16 or K16..K1 over a valid/ready handshake.
module des_key_schedule
   import des_pkg::*;
(
   input logic               clk,
   input logic               rst,
   des_key_schedule_if.slave bus
);

   state_t          state_q, state_d;
   logic [1:CD_W]   cd_q, cd_d;
   logic [1:CD_W]   pc1_cd;
   logic [3:0]      round_q, round_d;
   logic            mode_q, mode_d;
   logic [4:0]      shift_idx;
   logic [1:0]      shift_amt;
   logic            last_round;

   p_box_64_56 u_pc1 (
      .key (bus.key_i),
      .cd  (pc1_cd)
   );

   p_box_56_48 u_pc2 (
      .cd     (cd_q),
      .subkey (bus.subkey_o)
   );

   // Encrypt rotates by the round being entered; decrypt undoes the round being left
   assign shift_idx  = mode_q ? ({1'b0, round_q} + 5'd1) : ({1'b0, round_q} + 5'd2);
   assign shift_amt  = SHIFT_SCHED[shift_idx];
   assign last_round = mode_q ? (round_q == 4'd0) : (round_q == 4'd15);
   assign bus.round_o = round_q;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         cd_q    <= '0;
         round_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         round_q <= round_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      state_d            = state_q;
      cd_d               = cd_q;
      round_d            = round_q;
      mode_d             = mode_q;
      bus.subkey_valid_o = 1'b0;
      bus.busy_o         = 1'b0;
      bus.done_o         = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               mode_d  = bus.decrypt_i;
               cd_d    = bus.decrypt_i ? pc1_cd : rotl_cd(pc1_cd, 2'd1);
               round_d = bus.decrypt_i ? 4'd15 : 4'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            bus.subkey_valid_o = 1'b1;
            bus.busy_o         = 1'b1;
            if (bus.subkey_ready_i) begin
               if (last_round) begin
                  state_d = DONE;
               end else if (mode_q) begin
                  cd_d    = rotr_cd(cd_q, shift_amt);
                  round_d = round_q - 4'd1;
               end else begin
                  cd_d    = rotl_cd(cd_q, shift_amt);
                  round_d = round_q + 4'd1;
               end
            end
         end
         DONE: begin
            bus.done_o = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench: a driver queues expected subkeys from a table-driven DES model; a negedge monitor checks them.
module tb_des_key_schedule;

   localparam logic [63:0] REF_KEY = 64'h133457799BBCDFF1;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef struct packed {
      logic [47:0] subkey;
      logic [3:0]  round;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic monitor_on = 1'b0;
   logic done_due   = 1'b0;
   int   done_seen  = 0;
   int   checks     = 0;
   int   errors     = 0;
   exp_t sb[$];
   exp_t front;

   always #5 clk = ~clk;

   des_key_schedule_if bus();

   des_key_schedule dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Subkey n computed directly: C/D after the cumulative left shift of rounds 1..n
   function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
      logic [55:0] cd0;
      logic [55:0] cdn;
      logic [47:0] sk;
      int total;
      int src;
      total = 0;
      for (int r = 0; r < n; r++) total += SHIFTS[r];
      for (int j = 1; j <= 56; j++) cd0[56-j] = key[64-PC1_T[j-1]];
      for (int j = 1; j <= 28; j++) begin
         src         = ((j - 1 + total) % 28) + 1;
         cdn[56-j]   = cd0[56-src];
         cdn[28-j]   = cd0[28-src];
      end
      for (int k = 1; k <= 48; k++) sk[48-k] = cdn[56-PC2_T[k-1]];
      return sk;
   endfunction

   task automatic push_schedule(input logic [63:0] key, input logic dec);
      int n;
      for (int i = 0; i < 16; i++) begin
         n = dec ? (16 - i) : (i + 1);
         sb.push_back(exp_t'{ref_subkey(key, n), 4'(n - 1)});
      end
   endtask

   always @(negedge clk) begin
      if (monitor_on && !rst) begin
         check("valid", bus.subkey_valid_o, sb.size() != 0);
         check("busy", bus.busy_o, sb.size() != 0);
         check("done", bus.done_o, done_due);
         if (bus.done_o) done_seen++;
         done_due = 1'b0;
         if (bus.subkey_valid_o && sb.size() != 0) begin
            front = sb[0];
            check("subkey", bus.subkey_o, front.subkey);
            check("round", bus.round_o, front.round);
            if (bus.subkey_ready_i) begin
               void'(sb.pop_front());
               if (sb.size() == 0) done_due = 1'b1;
            end
         end
      end
   end

   // Caller is at posedge+1 with the DUT idle; returns in the IDLE cycle after DONE
   task automatic run_schedule(input logic [63:0] key, input logic dec, input int duty, input logic poke_start);
      int seen;
      int cyc;
      bus.key_i     = key;
      bus.decrypt_i = dec;
      bus.start_i   = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      push_schedule(key, dec);
      seen = done_seen;
      cyc  = 0;
      while (done_seen == seen && cyc < 2000) begin
         bus.subkey_ready_i = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
         if (poke_start && cyc == 5) begin
            bus.start_i   = 1'b1;
            bus.key_i     = {$urandom(), $urandom()};
            bus.decrypt_i = ~dec;
         end else begin
            bus.start_i = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.start_i = 1'b0;
      check("done_reached", done_seen != seen, 1'b1);
   endtask

   task automatic reset_mid_run();
      bus.key_i          = REF_KEY;
      bus.decrypt_i      = 1'b0;
      bus.start_i        = 1'b1;
      bus.subkey_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      push_schedule(REF_KEY, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      sb.delete();
      done_due = 1'b0;
      @(negedge clk);
      check("rst_valid", bus.subkey_valid_o, 1'b0);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_round", bus.round_o, 4'd0);
      check("rst_subkey", bus.subkey_o, 48'd0);
      check("rst_done", bus.done_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic back_to_back(input int n);
      logic [63:0] key;
      logic        dec;
      key = {$urandom(), $urandom()};
      dec = 1'b0;
      bus.subkey_ready_i = 1'b1;
      bus.key_i          = key;
      bus.decrypt_i      = dec;
      bus.start_i        = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         push_schedule(key, dec);
         if (i == n - 1) bus.start_i = 1'b0;
         key           = {$urandom(), $urandom()};
         dec           = ~dec;
         bus.key_i     = key;
         bus.decrypt_i = dec;
         if (i != n - 1) repeat (17) @(posedge clk);
      end
      repeat (20) @(posedge clk);
      #1;
      check("drained", sb.size(), 0);
   endtask

   initial begin
      rst                = 1'b1;
      bus.key_i          = '0;
      bus.decrypt_i      = 1'b0;
      bus.start_i        = 1'b0;
      bus.subkey_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", bus.subkey_valid_o, 1'b0);
      check("reset_busy", bus.busy_o, 1'b0);
      check("reset_done", bus.done_o, 1'b0);
      check("reset_round", bus.round_o, 4'd0);
      check("reset_subkey", bus.subkey_o, 48'd0);
      @(posedge clk); #1;
      rst        = 1'b0;
      monitor_on = 1'b1;

      check("model_k1", ref_subkey(REF_KEY, 1), 48'h1B02EFFC7072);
      check("model_k2", ref_subkey(REF_KEY, 2), 48'h79AED9DBC9E5);
      check("model_k16", ref_subkey(REF_KEY, 16), 48'hCB3D8B0E17F5);

      run_schedule(REF_KEY, 1'b0, 100, 1'b0);
      run_schedule(REF_KEY, 1'b1, 100, 1'b0);
      for (int i = 0; i < 6; i++) run_schedule({$urandom(), $urandom()}, i[0], 30, 1'b0);
      run_schedule({$urandom(), $urandom()}, 1'b0, 100, 1'b1);
      run_schedule({$urandom(), $urandom()}, 1'b1, 30, 1'b1);

      reset_mid_run();
      run_schedule(REF_KEY, 1'b0, 100, 1'b0);

      back_to_back(1000);

      monitor_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
